// File: rtl/ccw_frame_gen.sv
// Command-word frame generator: buffers one frame, streams header + payload.
// Optional trailing checksum word when CCW_FRAME_GEN_CSUM_EN is defined.
module ccw_frame_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6,
    parameter int DEPTH  = 63
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_d,
    input  logic              commit,
    input  logic              repeat_req,
    input  logic              tx_en,
    output logic              tx_rdy,
    output logic [DATA_W-1:0] tx_d,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [LEN_W-1:0]  frame_len,
    output logic              done,
    output logic              err
);

`ifdef CCW_FRAME_GEN_CSUM_EN
    typedef enum logic [2:0] {
        IDLE, ARMED, SEND_N, SEND_DATA, SEND_CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, ARMED, SEND_N, SEND_DATA
    } state_t;
`endif

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t state, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  wp, rp, wp_inc;
    logic              idle, fill_ok, commit_ok, repeat_ok;
    logic              err_set, last_xfer, rp_last;

    assign idle      = (state == IDLE);
    assign fill_ok   = idle && fill_en && (wp < DEPTH_L);
    assign wp_inc    = fill_ok ? wp + LEN_W'(1) : wp;
    assign commit_ok = idle && commit && (wp_inc != '0);
    assign repeat_ok = idle && repeat_req && !commit_ok
                    && (frame_len != '0);
    assign rp_last   = (rp == frame_len - LEN_W'(1));
    assign tx_rdy    = !idle;

    // Out-of-IDLE fill/commit and overflow fills are the only error sources
    assign err_set = idle ? (fill_en && (wp == DEPTH_L))
                          : (fill_en || commit);

`ifdef CCW_FRAME_GEN_CSUM_EN
    logic [DATA_W-1:0] csum_acc, csum;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            csum_acc <= '0;
            csum     <= '0;
        end else if (commit_ok) begin
            csum_acc <= '0;
            csum     <= csum_acc + (fill_ok ? fill_d : '0);
        end else if (fill_ok) begin
            csum_acc <= csum_acc + fill_d;
        end
    end
`endif

    always_comb begin
        state_d   = state;
        tx_valid  = 1'b0;
        tx_d      = '0;
        last_xfer = 1'b0;
        unique case (state)
            IDLE: begin
                if (commit_ok || repeat_ok) state_d = ARMED;
            end
            ARMED: begin
                if (tx_en) state_d = SEND_N;
            end
            SEND_N: begin
                tx_valid = 1'b1;
                tx_d     = DATA_W'(frame_len);
                if (tx_ready) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                tx_valid = 1'b1;
                tx_d     = mem[rp];
                if (tx_ready && rp_last) begin
`ifdef CCW_FRAME_GEN_CSUM_EN
                    state_d = SEND_CSUM;
`else
                    state_d   = IDLE;
                    last_xfer = 1'b1;
`endif
                end
            end
`ifdef CCW_FRAME_GEN_CSUM_EN
            SEND_CSUM: begin
                tx_valid = 1'b1;
                tx_d     = csum;
                if (tx_ready) begin
                    state_d   = IDLE;
                    last_xfer = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            frame_len <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            done  <= last_xfer;
            if (commit_ok) begin
                wp        <= '0;
                frame_len <= wp_inc;
            end else if (fill_ok) begin
                wp <= wp_inc;
            end
            if (state == SEND_N && tx_ready)
                rp <= '0;
            else if (state == SEND_DATA && tx_ready)
                rp <= rp + LEN_W'(1);
            if (commit_ok)
                err <= 1'b0;
            else if (err_set)
                err <= 1'b1;
        end
    end

    // Payload storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (fill_ok) mem[wp] <= fill_d;
    end

endmodule

// File: tb/tb_ccw_frame_gen.sv
// Bench for ccw_frame_gen: randomized frames against a queue-based model.
// Define CCW_FRAME_GEN_CSUM_EN to expect the trailing checksum word.
module tb_ccw_frame_gen;
    localparam int DW    = 8;
    localparam int LW    = 6;
    localparam int DEPTH = 63;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          fill_en = 1'b0;
    logic [DW-1:0] fill_d = '0;
    logic          commit = 1'b0;
    logic          repeat_req = 1'b0;
    logic          tx_en = 1'b0;
    logic          tx_ready = 1'b0;
    logic          tx_rdy, tx_valid, done, err;
    logic [DW-1:0] tx_d;
    logic [LW-1:0] frame_len;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] pl[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got[$];

    always #5 clk = ~clk;

    ccw_frame_gen #(.DATA_W(DW), .LEN_W(LW), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .fill_en(fill_en), .fill_d(fill_d),
        .commit(commit), .repeat_req(repeat_req), .tx_en(tx_en),
        .tx_rdy(tx_rdy), .tx_d(tx_d), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .frame_len(frame_len), .done(done),
        .err(err)
    );

    // Expected stream: length header, payload, optional modular sum
    task automatic make_exp();
        logic [DW-1:0] sum;
        sum = '0;
        exp_q = {};
        exp_q.push_back(DW'(pl.size()));
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            sum = sum + pl[i];
        end
`ifdef CCW_FRAME_GEN_CSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    function automatic int diff_count();
        int n;
        n = 0;
        if (got.size() != exp_q.size()) return 1000;
        foreach (exp_q[i]) if (got[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic rand_payload(input int n);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(DW'($urandom));
    endtask

    task automatic do_fill();
        foreach (pl[i]) begin
            fill_en = 1'b1;
            fill_d  = pl[i];
            @(negedge clk);
        end
        fill_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic pulse_repeat();
        repeat_req = 1'b1;
        @(negedge clk);
        repeat_req = 1'b0;
    endtask

    // mode 0: ready high, 1: alternate 1/0, 2: random
    task automatic send(input int mode, input bit inject,
                        output bit tmo, output int stall_err,
                        output int lat, output int vcyc);
        bit            held;
        logic [DW-1:0] hd;
        got = {};
        tmo = 1'b1;
        stall_err = 0;
        lat = -1;
        vcyc = 0;
        held = 1'b0;
        hd = '0;
        @(negedge clk);
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (held && (!tx_valid || tx_d !== hd)) stall_err++;
            if (tx_valid && lat < 0) lat = cyc;
            if (tx_valid) vcyc++;
            tx_ready = (mode == 0) ? 1'b1 :
                       (mode == 1) ? cyc[0] :
                       1'($urandom_range(0, 1));
            fill_en = inject && (vcyc == 3);
            fill_d  = DW'($urandom);
            held = tx_valid && !tx_ready;
            hd   = tx_d;
            if (tx_valid && tx_ready) got.push_back(tx_d);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        fill_en  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (tx_valid !== 1'b0 || tx_rdy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: valid=%b rdy=%b done=%b, required 000",
                     tx_valid, tx_rdy, done);
        end
        tests++;
        if (tx_d !== '0 || frame_len !== '0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: tx_d=%h len=%0d err=%b, required 0/0/0",
                     tx_d, frame_len, err);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit tmo;
        int se, lat, vc;
        pl = '{8'h11, 8'h22, 8'h33};
        make_exp();
        do_fill();
        do_commit();
        tests++;
        if (tx_rdy !== 1'b1 || frame_len !== LW'(3)) begin
            fails++;
            $display("FAIL basic_commit: rdy=%b len=%0d, required 1/3",
                     tx_rdy, frame_len);
        end
        send(0, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || lat !== 1) begin
            fails++;
            $display("FAIL basic_timing: timeout=%b latency=%0d, required 0/1",
                     tmo, lat);
        end
        tests++;
        if (vc !== exp_q.size()) begin
            fails++;
            $display("FAIL basic_cycles: %0d valid cycles, required %0d",
                     vc, exp_q.size());
        end
        tests++;
        if (diff_count() !== 0) begin
            fails++;
            $display("FAIL basic_stream: %0d words bad, required 0",
                     diff_count());
        end
        tests++;
        if (tx_valid !== 1'b0 || tx_rdy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: valid=%b rdy=%b at done, required 0/0",
                     tx_valid, tx_rdy);
        end
    endtask

    task automatic test_stall();
        bit tmo;
        int se, lat, vc;
        do_fill();
        do_commit();
        send(1, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || se !== 0) begin
            fails++;
            $display("FAIL stall_hold: timeout=%b unstable=%0d, required 0/0",
                     tmo, se);
        end
        tests++;
        if (diff_count() !== 0) begin
            fails++;
            $display("FAIL stall_stream: %0d words bad, required 0",
                     diff_count());
        end
    endtask

    task automatic test_repeat();
        bit tmo;
        int se, lat, vc;
        pulse_repeat();
        tests++;
        if (tx_rdy !== 1'b1) begin
            fails++;
            $display("FAIL repeat_arm: rdy=%b, required 1", tx_rdy);
        end
        send(0, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || diff_count() !== 0) begin
            fails++;
            $display("FAIL repeat_stream: timeout=%b bad=%0d, required 0/0",
                     tmo, diff_count());
        end
    endtask

    task automatic test_overflow();
        bit tmo;
        int se, lat, vc;
        rand_payload(DEPTH);
        make_exp();
        do_fill();
        fill_en = 1'b1;
        fill_d  = DW'($urandom);
        @(negedge clk);
        fill_en = 1'b0;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_err: err=%b, required 1", err);
        end
        do_commit();
        tests++;
        if (frame_len !== LW'(DEPTH) || err !== 1'b0) begin
            fails++;
            $display("FAIL ovf_commit: len=%0d err=%b, required %0d/0",
                     frame_len, err, DEPTH);
        end
        send(2, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || se !== 0 || diff_count() !== 0) begin
            fails++;
            $display("FAIL ovf_stream: timeout=%b unstable=%0d bad=%0d, required 0",
                     tmo, se, diff_count());
        end
    endtask

    task automatic test_err_send();
        bit tmo;
        int se, lat, vc;
        rand_payload(5);
        make_exp();
        do_fill();
        do_commit();
        send(0, 1'b1, tmo, se, lat, vc);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL send_fill_err: err=%b, required 1", err);
        end
        tests++;
        if (tmo !== 1'b0 || diff_count() !== 0) begin
            fails++;
            $display("FAIL send_fill_stream: timeout=%b bad=%0d, required 0/0",
                     tmo, diff_count());
        end
        pulse_repeat();
        send(0, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || diff_count() !== 0) begin
            fails++;
            $display("FAIL send_fill_buffer: timeout=%b bad=%0d, required 0/0",
                     tmo, diff_count());
        end
        do_commit();
        tests++;
        if (tx_rdy !== 1'b0 || err !== 1'b1 || frame_len !== LW'(5)) begin
            fails++;
            $display("FAIL empty_commit: rdy=%b err=%b len=%0d, required 0/1/5",
                     tx_rdy, err, frame_len);
        end
        // Final word written in the same cycle as commit
        rand_payload(2);
        make_exp();
        fill_en = 1'b1;
        fill_d  = pl[0];
        @(negedge clk);
        fill_d  = pl[1];
        commit  = 1'b1;
        @(negedge clk);
        fill_en = 1'b0;
        commit  = 1'b0;
        tests++;
        if (frame_len !== LW'(2) || err !== 1'b0 || tx_rdy !== 1'b1) begin
            fails++;
            $display("FAIL fill_commit: len=%0d err=%b rdy=%b, required 2/0/1",
                     frame_len, err, tx_rdy);
        end
        send(0, 1'b0, tmo, se, lat, vc);
        tests++;
        if (tmo !== 1'b0 || diff_count() !== 0) begin
            fails++;
            $display("FAIL fill_commit_stream: timeout=%b bad=%0d, required 0/0",
                     tmo, diff_count());
        end
    endtask

    task automatic test_reset_mid();
        rand_payload(10);
        do_fill();
        do_commit();
        tx_en = 1'b1;
        @(negedge clk);
        tx_en    = 1'b0;
        tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_active: valid=%b before reset, required 1",
                     tx_valid);
        end
        #2 n_rst = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || tx_rdy !== 1'b0 || frame_len !== '0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b rdy=%b len=%0d, required 0/0/0",
                     tx_valid, tx_rdy, frame_len);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        pulse_repeat();
        tests++;
        if (tx_rdy !== 1'b0) begin
            fails++;
            $display("FAIL mid_repeat: rdy=%b after reset, required 0", tx_rdy);
        end
    endtask

    task automatic test_random();
        bit tmo;
        int se, lat, vc, n;
        for (int it = 0; it < 20; it++) begin
            if (it == 0 || $urandom_range(0, 3) != 0) begin
                n = $urandom_range(1, DEPTH);
                rand_payload(n);
                make_exp();
                do_fill();
                do_commit();
                tests++;
                if (frame_len !== LW'(n) || tx_rdy !== 1'b1) begin
                    fails++;
                    $display("FAIL rand_commit[%0d]: len=%0d rdy=%b, required %0d/1",
                             it, frame_len, tx_rdy, n);
                end
            end else begin
                pulse_repeat();
            end
            send(2, 1'b0, tmo, se, lat, vc);
            tests++;
            if (tmo !== 1'b0 || se !== 0 || diff_count() !== 0) begin
                fails++;
                $display("FAIL rand_stream[%0d]: timeout=%b unstable=%0d bad=%0d, required 0",
                         it, tmo, se, diff_count());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_repeat();
        test_overflow();
        test_err_send();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
